fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: decode-side and instruction-memory signals of the fetch stage.
// fetch_misaligned_o exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if;
    logic        incr_pc_i;
    logic        pc_load_i;
    logic [31:0] pc_load_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] d_inst_o;
    logic [31:0] d_pc_o;
    logic        d_valid_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned_o;
`endif
    modport master (
        input  incr_pc_i, pc_load_i, pc_load_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
`ifdef FETCH_MISALIGN_TRAP_EN
        output fetch_misaligned_o,
`endif
        output imem_req_o, imem_addr_o, d_inst_o, d_pc_o, d_valid_o
    );
    modport slave (
        output incr_pc_i, pc_load_i, pc_load_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  fetch_misaligned_o,
`endif
        input  imem_req_o, imem_addr_o, d_inst_o, d_pc_o, d_valid_o
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC owner with prefetch FIFO, in-order response tracking and redirect flush.
// Define FETCH_MISALIGN_TRAP_EN for a sticky misaligned-redirect flag that halts fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input logic          clk_i,
    input logic          rst_n_i,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    typedef enum logic {BOOT, RUN} state_t;
    state_t state_q, state_d;
    logic [31:0] fetch_addr_q, resp_pc_q, last_pc_q, tgt;
    logic [31:0] fifo_pc_q [FIFO_DEPTH];
    logic [31:0] fifo_inst_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, outstanding_cnt, discard_cnt, owed;
    logic trap_q, misal, load, rv, drop, push, pop, req, fire;

    always_comb begin
        state_d = (state_q == BOOT) ? RUN : state_q;
        load    = bus.pc_load_i;
        tgt     = {bus.pc_load_addr_i[31:2], 2'b00};
        misal   = TRAP_EN && (bus.pc_load_addr_i[1:0] != 2'b00);
        rv      = bus.imem_rvalid_i && (outstanding_cnt != '0);
        drop    = rv && (discard_cnt != '0);
        push    = rv && !drop && !load;
        pop     = (count_q != '0) && bus.incr_pc_i && !load;
        req     = (state_q == RUN) && !load && !trap_q && (({1'b0, outstanding_cnt} + {1'b0, count_q}) < DEPTH_W);
        fire    = req && bus.imem_gnt_i;
        // every response still owed after this edge; on redirect all of them become stale
        owed    = outstanding_cnt + CW'(fire) - CW'(rv);
        bus.imem_req_o  = req;
        bus.imem_addr_o = fetch_addr_q;
        bus.d_valid_o   = count_q != '0;
        bus.d_inst_o    = (count_q != '0) ? fifo_inst_q[rd_q] : NOP_INST;
        bus.d_pc_o      = (count_q != '0) ? fifo_pc_q[rd_q] : last_pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= BOOT;
            fetch_addr_q    <= RESET_PC;
            resp_pc_q       <= RESET_PC;
            last_pc_q       <= RESET_PC;
            rd_q            <= '0;
            wr_q            <= '0;
            count_q         <= '0;
            outstanding_cnt <= '0;
            discard_cnt     <= '0;
            trap_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            outstanding_cnt <= owed;
            if (load && misal) last_pc_q <= bus.pc_load_addr_i;
            else if (count_q != '0) last_pc_q <= fifo_pc_q[rd_q];
            if (load) begin
                fetch_addr_q <= tgt;
                resp_pc_q    <= tgt;
                discard_cnt  <= owed;
                trap_q       <= misal;
                rd_q         <= '0;
                wr_q         <= '0;
                count_q      <= '0;
            end else begin
                if (fire) fetch_addr_q <= fetch_addr_q + 32'd4;
                if (drop) discard_cnt <= discard_cnt - CW'(1);
                if (push) begin
                    wr_q      <= wr_q + PW'(1);
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (pop) rd_q <= rd_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc_q[wr_q]   <= resp_pc_q;
            fifo_inst_q[wr_q] <= bus.imem_rdata_i;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_misaligned_o = trap_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory model plus scoreboard of the architectural instruction stream.
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    typedef struct {logic [31:0] addr; int ready;} mreq_t;
    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    int errors = 0, checks = 0, consumed = 0, cyc = 0;
    int lat_min = 1, lat_max = 1, gnt_pct = 100;
    logic        pr = 1'b0, pg = 1'b0;
    logic [31:0] pa = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // the architectural stream restarts at the (word-aligned) target
    task automatic set_exp(input logic [31:0] t);
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) return;
`endif
        for (int i = 0; i < 256; i++) exp_q.push_back({t[31:2], 2'b00} + 32'(4 * i));
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.pc_load_i = 1'b1;
        bus.pc_load_addr_i = t;
        set_exp(t);
        tick();
        bus.pc_load_i = 1'b0;
    endtask

    task automatic wait_valid(input logic [31:0] pc, input int limit, input string name);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            if (bus.d_valid_o && bus.d_pc_o == pc) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: pc %h not presented within %0d cycles", name, pc, limit);
        end
    endtask

    // instruction memory: random grant, in-order responses after 1..N cycles
    initial begin
        int r;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                pr = 1'b0;
            end else begin
                if (pr && !pg && !bus.pc_load_i) begin
                    chk("req_hold", {31'b0, bus.imem_req_o}, 32'd1);
                    chk("addr_hold", bus.imem_addr_o, pa);
                end
                if (bus.imem_rvalid_i) void'(mq.pop_front());
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    r = cyc + int'($urandom_range(lat_max, lat_min));
                    if (mq.size() > 0 && r <= mq[$].ready) r = mq[$].ready + 1;
                    mq.push_back('{addr: bus.imem_addr_o, ready: r});
                    chk("addr_align", {30'b0, bus.imem_addr_o[1:0]}, 32'd0);
                    chk("outstanding_limit", {31'b0, mq.size() <= DEPTH}, 32'd1);
                end
                pr = bus.imem_req_o;
                pg = bus.imem_gnt_i;
                pa = bus.imem_addr_o;
            end
            @(posedge clk);
            #1;
            bus.imem_gnt_i = rst_n && ($urandom_range(99, 0) < gnt_pct);
            if (rst_n && mq.size() > 0 && mq[0].ready <= cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i = mq[0].addr ^ KEY;
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i = $urandom;
            end
        end
    end

    // monitor: every instruction accepted by decode must be the next one of the stream
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus.d_valid_o) chk("nop_when_empty", bus.d_inst_o, NOP);
                else if (bus.incr_pc_i && !bus.pc_load_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got pc %h expected no instruction", bus.d_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("d_pc", bus.d_pc_o, e);
                        chk("d_inst", bus.d_inst_o, e ^ KEY);
                        consumed++;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit hit;
        bus.incr_pc_i = 1'b0;
        bus.pc_load_i = 1'b0;
        bus.pc_load_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_inst", bus.d_inst_o, NOP);
        chk("rst_pc", bus.d_pc_o, 32'h0);
        chk("rst_valid", {31'b0, bus.d_valid_o}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misaligned", {31'b0, bus.fetch_misaligned_o}, 32'd0);
`endif
        set_exp(32'h0);
        rst_n = 1'b1;
        chk("boot_no_req", {31'b0, bus.imem_req_o}, 32'd0);
        // fill and stream, then stall while PC 0x8 is presented
        bus.incr_pc_i = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (bus.d_valid_o && bus.d_pc_o == 32'h8) hit = 1;
            else tick();
        end
        chk("reach_pc8", {31'b0, hit}, 32'd1);
        bus.incr_pc_i = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_pc", bus.d_pc_o, 32'h8);
            chk("stall_inst", bus.d_inst_o, 32'h8 ^ KEY);
            chk("stall_valid", {31'b0, bus.d_valid_o}, 32'd1);
        end
        bus.incr_pc_i = 1'b1;
        wait_valid(32'hC, 10, "resume_pc_c");
        // redirect with two slow responses in flight
        lat_min = 3;
        lat_max = 3;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (mq.size() == 2) hit = 1;
            else tick();
        end
        chk("two_in_flight", {31'b0, hit}, 32'd1);
        redirect(32'h100);
        for (int i = 0; i < 30 && !bus.d_valid_o; i++) tick();
        chk("first_after_redirect", bus.d_pc_o, 32'h100);
        // redirect-to-decode latency with a single-cycle memory
        lat_min = 1;
        lat_max = 1;
        repeat (10) tick();
        redirect(32'h40);
        chk("lat_n1_valid", {31'b0, bus.d_valid_o}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'b0, bus.d_valid_o}, 32'd0);
        tick();
        chk("lat_n3_valid", {31'b0, bus.d_valid_o}, 32'd1);
        chk("lat_n3_pc", bus.d_pc_o, 32'h40);
        // address wrap and back-to-back redirects
        redirect(32'hFFFF_FFF8);
        wait_valid(32'h0, 40, "wrap_to_zero");
        redirect(32'h300);
        redirect(32'h400);
        wait_valid(32'h404, 40, "last_redirect_wins");
        // randomized traffic
        gnt_pct = 70;
        lat_max = 3;
        for (int i = 0; i < 700; i++) begin
            bus.incr_pc_i = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0)
                redirect(($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC));
            else tick();
        end
        // reset mid-operation
        bus.incr_pc_i = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", {31'b0, bus.d_valid_o}, 32'd0);
        chk("mid_rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("mid_rst_pc", bus.d_pc_o, 32'h0);
        set_exp(32'h0);
        rst_n = 1'b1;
        wait_valid(32'h4, 60, "after_mid_reset");
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect(32'h102);
        chk("mis_flag", {31'b0, bus.fetch_misaligned_o}, 32'd1);
        chk("mis_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("mis_pc", bus.d_pc_o, 32'h102);
        repeat (6) tick();
        chk("mis_req_held", {31'b0, bus.imem_req_o}, 32'd0);
        chk("mis_flag_held", {31'b0, bus.fetch_misaligned_o}, 32'd1);
        redirect(32'h200);
        chk("mis_cleared", {31'b0, bus.fetch_misaligned_o}, 32'd0);
        wait_valid(32'h200, 30, "after_mis_clear");
`endif
        repeat (5) tick();
        checks++;
        if (consumed < 50) begin
            errors++;
            $display("FAIL progress: got %0d instructions expected at least 50", consumed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
